wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
Writeback arbiter in front of the 32 x 64-bit register file's single write port. It merges two writeback sources: the in-order pipeline, which has fixed priority and cannot be back-pressured, and the long-latency unit (load/multiply), which uses a valid/ready handshake and is buffered in a small FIFO. It drives the register-file write port from registered outputs. It also exports pending-write flags and a starvation stall request to the hazard unit.

Parameters:
DATA_W, 64, writeback data width
ADDR_W, 5, register address width
DEPTH, 4, long-latency FIFO entries (power of 2, >=2)
STARVE_LIMIT, 8, consecutive blocked cycles before stall_req asserts
ZERO_REG, 31, hard-wired zero register (XZR); writes to it are discarded

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
pipe_wb_valid  in  1  pipeline writeback request this cycle
pipe_wb_dest  in  ADDR_W  pipeline destination register
pipe_wb_data  in  DATA_W  pipeline result
lu_valid  in  1  long-latency result valid
lu_ready  out  1  arbiter can accept lu result (= !fifo_full)
lu_dest  in  ADDR_W  long-latency destination register
lu_data  in  DATA_W  long-latency result
reg_write  out  1  register-file write enable
reg_write_dest  out  ADDR_W  register-file write address
reg_write_data  out  DATA_W  register-file write data
query_addr_1  in  ADDR_W  hazard query address (read port 1)
query_addr_2  in  ADDR_W  hazard query address (read port 2)
pend_1  out  1  write to query_addr_1 queued or in flight
pend_2  out  1  write to query_addr_2 queued or in flight
stall_req  out  1  request pipeline bubble so FIFO can drain

Behaviour:
- Reset (async, rst_n=0):
  - FIFO pointers, count and starvation counter cleared to 0.
  - reg_write, reg_write_dest and reg_write_data all 0.
  - lu_ready=1, stall_req=0, pend_1/pend_2=0.
- Effective requests:
  - pipe_req = pipe_wb_valid && pipe_wb_dest != ZERO_REG.
  - An lu handshake (lu_valid && lu_ready) with lu_dest == ZERO_REG completes normally but is not enqueued.
- Enqueue: on handshake with dest != ZERO_REG, write {dest,data} at the tail. lu_ready depends on fullness only. There is no pass-through, so no push occurs while full, even if a pop happens the same cycle.
- Arbitration, evaluated each cycle from current state:
  - If pipe_req: issue the pipe write; FIFO holds.
  - Else if FIFO non-empty: issue the FIFO head and pop.
  - Else: issue nothing.
- Simultaneous push and pop: count unchanged; pointers both advance; wrap-around modulo DEPTH.
- Output register: reg_write, reg_write_dest and reg_write_data load the issued write on the rising edge. When nothing is issued, reg_write=0 and dest/data hold their previous values.
- Latency:
  - Pipe request in cycle N -> reg_write=1 in cycle N+1 -> register file commits at edge ending N+1.
  - lu handshake in cycle N with the pipe idle afterward -> pop in N+1 -> reg_write in N+2.
- Starvation:
  - Counter increments each cycle the FIFO is non-empty and pipe_req=1, saturating at STARVE_LIMIT.
  - It clears on any pop or when the FIFO is empty.
  - stall_req = (counter == STARVE_LIMIT) || fifo_full, driven combinationally from registered state.
  - The upstream guarantees pipe_wb_valid=0 in any cycle stall_req=1. If it violates this, the pipe still wins, nothing is corrupted, and stall_req stays high.
- Pending flags:
  - pend_k=1 when any valid FIFO entry's dest == query_addr_k, or when reg_write=1 && reg_write_dest == query_addr_k.
  - Never set for ZERO_REG. Purely combinational.
- Ordering:
  - FIFO entries drain in arrival order.
  - Ordering between the pipe and the FIFO for the same register is not enforced here; the hazard unit uses pend_k to prevent it.
- Reset mid-operation: queued writes are lost; reg_write drops to 0 immediately (async).

Decomposition:
- Package cpu_pkg: DATA_W, ADDR_W, ZERO_REG constants; typedef wb_req_t {dest, data}.
- One sub-module, wb_fifo:
  - Parameterised DEPTH x wb_req_t with push, pop, full and empty.
  - Exposes per-entry valid/dest vectors for the pending compare.
- Arbitration, output register, starvation counter and pending compare stay in wb_arbiter.

Test Plan:
- Reset -> reg_write=0, lu_ready=1, stall_req=0; pipe write X5=0x1234 in cycle N -> reg_write=1, dest=5, data=0x1234 in N+1.
- Pipe idle, lu push X7=0xDEAD -> reg_write with dest=7 two cycles after the handshake; pend_1 (query 7) high from the cycle after the handshake until reg_write deasserts.
- Pipe valid every cycle, 4 lu pushes -> FIFO full, lu_ready=0, stall_req=1; drop pipe_wb_valid -> 4 writes drain in push order, lu_ready back to 1 after the first pop.
- One FIFO entry and pipe continuously valid -> stall_req asserts after exactly 8 blocked cycles and clears the cycle after the pop.
- Writes to X31 from both sources -> no reg_write, no enqueue, lu handshake completes, pend never set.
- Push/pop simultaneously across the pointer wrap (12 mixed transactions) -> data and order intact; assert rst_n=0 with 3 entries queued -> FIFO empty and reg_write=0 immediately.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared writeback types and constants for the register-file write path.
package cpu_pkg;

  localparam int DATA_W = 64;
  localparam int ADDR_W = 5;
  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  // XZR is never a real destination: writes to it and hazards on it are ignored.
  function automatic logic is_real_dest(input logic [ADDR_W-1:0] dest);
    return dest != ZERO_REG;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Circular FIFO of writeback requests; exposes per-slot valid/dest for hazard compares.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          push_i,
  input  wb_req_t                       push_data_i,
  input  logic                          pop_i,
  output wb_req_t                       head_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [DEPTH-1:0]              valid_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  dest_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_req_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_push, do_pop;

  assign full_o  = count_q == CNT_W'(DEPTH);
  assign empty_o = count_q == '0;
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // NOTE: storage is not reset; a slot only matters once count_q marks it valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic [PTR_W-1:0] offs;
    assign offs       = PTR_W'(g) - rd_ptr_q;
    assign valid_o[g] = CNT_W'(offs) < count_q;
    assign dest_o[g]  = mem_q[g].dest;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: fixed-priority pipeline vs buffered long-latency unit onto one
// register-file write port, with pending-write flags and a starvation stall request.
module wb_arbiter
  import cpu_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_wb_valid,
  input  logic [ADDR_W-1:0] pipe_wb_dest,
  input  logic [DATA_W-1:0] pipe_wb_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_dest,
  input  logic [DATA_W-1:0] lu_data,
  output logic              reg_write,
  output logic [ADDR_W-1:0] reg_write_dest,
  output logic [DATA_W-1:0] reg_write_data,
  input  logic [ADDR_W-1:0] query_addr_1,
  input  logic [ADDR_W-1:0] query_addr_2,
  output logic              pend_1,
  output logic              pend_2,
  output logic              stall_req
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  wb_req_t                      fifo_head;
  logic                         fifo_full, fifo_empty, fifo_push, fifo_pop, pipe_req;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_dest;

  logic                reg_write_q, reg_write_d;
  logic [ADDR_W-1:0]   dest_q, dest_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [STARVE_W-1:0] starve_q, starve_d;

  assign pipe_req  = pipe_wb_valid && is_real_dest(pipe_wb_dest);
  assign lu_ready  = !fifo_full;
  assign fifo_push = lu_valid && lu_ready && is_real_dest(lu_dest);
  assign fifo_pop  = !pipe_req && !fifo_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (fifo_push),
    .push_data_i ('{dest: lu_dest, data: lu_data}),
    .pop_i       (fifo_pop),
    .head_o      (fifo_head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .valid_o     (ent_valid),
    .dest_o      (ent_dest)
  );

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    reg_write_d = 1'b0;
    dest_d      = dest_q;
    data_d      = data_q;
    starve_d    = '0;
    if (pipe_req) begin
      reg_write_d = 1'b1;
      dest_d      = pipe_wb_dest;
      data_d      = pipe_wb_data;
    end else if (!fifo_empty) begin
      reg_write_d = 1'b1;
      dest_d      = fifo_head.dest;
      data_d      = fifo_head.data;
    end
    // Any cycle that is not "queued but blocked" is either a pop or an empty FIFO.
    if (pipe_req && !fifo_empty)
      starve_d = (starve_q == STARVE_MAX) ? starve_q : starve_q + STARVE_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      dest_q      <= '0;
      data_q      <= '0;
      starve_q    <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      dest_q      <= dest_d;
      data_q      <= data_d;
      starve_q    <= starve_d;
    end
  end

  assign reg_write      = reg_write_q;
  assign reg_write_dest = dest_q;
  assign reg_write_data = data_q;
  assign stall_req      = (starve_q == STARVE_MAX) || fifo_full;

  always_comb begin
    pend_1 = reg_write_q && dest_q == query_addr_1;
    pend_2 = reg_write_q && dest_q == query_addr_2;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_dest[i] == query_addr_1) pend_1 = 1'b1;
      if (ent_valid[i] && ent_dest[i] == query_addr_2) pend_2 = 1'b1;
    end
    pend_1 = pend_1 && is_real_dest(query_addr_1);
    pend_2 = pend_2 && is_real_dest(query_addr_2);
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench: queue-based writeback model compared every cycle, plus directed literal checks.
module tb_wb_arbiter;
  import cpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pipe_wb_valid, lu_valid, lu_ready;
  logic [ADDR_W-1:0] pipe_wb_dest, lu_dest, reg_write_dest, query_addr_1, query_addr_2;
  logic [DATA_W-1:0] pipe_wb_data, lu_data, reg_write_data;
  logic              reg_write, pend_1, pend_2, stall_req;

  wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .pipe_wb_valid  (pipe_wb_valid),
    .pipe_wb_dest   (pipe_wb_dest),
    .pipe_wb_data   (pipe_wb_data),
    .lu_valid       (lu_valid),
    .lu_ready       (lu_ready),
    .lu_dest        (lu_dest),
    .lu_data        (lu_data),
    .reg_write      (reg_write),
    .reg_write_dest (reg_write_dest),
    .reg_write_data (reg_write_data),
    .query_addr_1   (query_addr_1),
    .query_addr_2   (query_addr_2),
    .pend_1         (pend_1),
    .pend_2         (pend_2),
    .stall_req      (stall_req)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a plain queue of pending writes plus the last issued write.
  typedef struct {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } ent_t;

  ent_t              mq[$];
  logic              m_we     = 1'b0;
  logic [ADDR_W-1:0] m_dest   = '0;
  logic [DATA_W-1:0] m_data   = '0;
  int                m_starve = 0;

  function automatic logic model_pend(input logic [ADDR_W-1:0] a);
    if (a == 5'd31) return 1'b0;
    foreach (mq[i]) if (mq[i].dest == a) return 1'b1;
    return m_we && m_dest == a;
  endfunction

  function automatic logic model_stall();
    return (m_starve == LIMIT) || (mq.size() == DEPTH);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_we = 1'b0; m_dest = '0; m_data = '0; m_starve = 0;
    end else begin
      bit   preq, hs, had;
      ent_t e;
      preq = pipe_wb_valid && pipe_wb_dest != 5'd31;
      hs   = lu_valid && mq.size() < DEPTH;
      had  = mq.size() > 0;
      if (preq) begin
        m_we = 1'b1; m_dest = pipe_wb_dest; m_data = pipe_wb_data;
        m_starve = had ? ((m_starve < LIMIT) ? m_starve + 1 : LIMIT) : 0;
      end else if (had) begin
        e = mq.pop_front();
        m_we = 1'b1; m_dest = e.dest; m_data = e.data;
        m_starve = 0;
      end else begin
        m_we = 1'b0;
        m_starve = 0;
      end
      if (hs && lu_dest != 5'd31) begin
        e.dest = lu_dest; e.data = lu_data;
        mq.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_reg_write", 64'(reg_write), 64'(m_we));
      check("m_dest", 64'(reg_write_dest), 64'(m_dest));
      check("m_data", reg_write_data, m_data);
      check("m_lu_ready", 64'(lu_ready), 64'(mq.size() < DEPTH));
      check("m_stall_req", 64'(stall_req), 64'(model_stall()));
      check("m_pend_1", 64'(pend_1), 64'(model_pend(query_addr_1)));
      check("m_pend_2", 64'(pend_2), 64'(model_pend(query_addr_2)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pipe_wb_valid = 1'b0;
    lu_valid      = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DATA_W-1:0] wrap_data [13];

  initial begin
    rst_n = 1'b0;
    pipe_wb_valid = 1'b0; pipe_wb_dest = '0; pipe_wb_data = '0;
    lu_valid = 1'b0; lu_dest = '0; lu_data = '0;
    query_addr_1 = '0; query_addr_2 = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_reg_write", 64'(reg_write), 64'h0);
    check("rst_data", reg_write_data, 64'h0);
    check("rst_lu_ready", 64'(lu_ready), 64'h1);
    check("rst_stall", 64'(stall_req), 64'h0);
    check("rst_pend_1", 64'(pend_1), 64'h0);
    tick();
    rst_n = 1'b1;
    cmp_en = 1'b1;
    tick();

    // Pipe write X5 -> visible one cycle later.
    pipe_wb_valid = 1'b1; pipe_wb_dest = 5'd5; pipe_wb_data = 64'h1234;
    tick();
    idle_inputs();
    @(negedge clk);
    check("pipe_we", 64'(reg_write), 64'h1);
    check("pipe_dest", 64'(reg_write_dest), 64'd5);
    check("pipe_data", reg_write_data, 64'h1234);

    // LU write X7 -> reg_write two cycles after the handshake.
    tick();
    lu_valid = 1'b1; lu_dest = 5'd7; lu_data = 64'hDEAD; query_addr_1 = 5'd7;
    @(negedge clk);
    check("lu_hs_ready", 64'(lu_ready), 64'h1);
    tick();
    lu_valid = 1'b0;
    @(negedge clk);
    check("lu_n1_pend", 64'(pend_1), 64'h1);
    check("lu_n1_we", 64'(reg_write), 64'h0);
    tick();
    @(negedge clk);
    check("lu_n2_we", 64'(reg_write), 64'h1);
    check("lu_n2_dest", 64'(reg_write_dest), 64'd7);
    check("lu_n2_data", reg_write_data, 64'hDEAD);
    check("lu_n2_pend", 64'(pend_1), 64'h1);
    tick();
    @(negedge clk);
    check("lu_n3_we", 64'(reg_write), 64'h0);
    check("lu_n3_pend", 64'(pend_1), 64'h0);

    // Fill the FIFO under pipe pressure, then drain in order.
    tick();
    for (int k = 0; k < 4; k++) begin
      pipe_wb_valid = 1'b1; pipe_wb_dest = 5'd1; pipe_wb_data = 64'(k);
      lu_valid = 1'b1; lu_dest = 5'(10 + k); lu_data = 64'hA0 + 64'(k);
      tick();
    end
    idle_inputs();
    @(negedge clk);
    check("full_lu_ready", 64'(lu_ready), 64'h0);
    check("full_stall", 64'(stall_req), 64'h1);
    for (int k = 0; k < 4; k++) begin
      tick();
      @(negedge clk);
      check("drain_dest", 64'(reg_write_dest), 64'(10 + k));
      check("drain_data", reg_write_data, 64'hA0 + 64'(k));
      if (k == 0) check("drain_lu_ready", 64'(lu_ready), 64'h1);
    end
    tick();
    @(negedge clk);
    check("drain_done_we", 64'(reg_write), 64'h0);

    // Starvation: one queued entry blocked by a continuous pipe stream.
    tick();
    pipe_wb_valid = 1'b1; pipe_wb_dest = 5'd2; pipe_wb_data = 64'h22;
    lu_valid = 1'b1; lu_dest = 5'd20; lu_data = 64'hBEEF;
    tick();
    lu_valid = 1'b0;
    for (int b = 1; b <= 8; b++) begin
      @(negedge clk);
      check("starve_low", 64'(stall_req), 64'h0);
      tick();
    end
    pipe_wb_valid = 1'b0;
    @(negedge clk);
    check("starve_high", 64'(stall_req), 64'h1);
    tick();
    @(negedge clk);
    check("starve_clear", 64'(stall_req), 64'h0);
    check("starve_pop_dest", 64'(reg_write_dest), 64'd20);
    check("starve_pop_data", reg_write_data, 64'hBEEF);

    // XZR writes from both sources are dropped.
    tick();
    pipe_wb_valid = 1'b1; pipe_wb_dest = 5'd31; pipe_wb_data = 64'h5;
    lu_valid = 1'b1; lu_dest = 5'd31; lu_data = 64'h6; query_addr_1 = 5'd31;
    @(negedge clk);
    check("xzr_lu_ready", 64'(lu_ready), 64'h1);
    check("xzr_pend_a", 64'(pend_1), 64'h0);
    tick();
    idle_inputs();
    @(negedge clk);
    check("xzr_we_a", 64'(reg_write), 64'h0);
    check("xzr_pend_b", 64'(pend_1), 64'h0);
    tick();
    @(negedge clk);
    check("xzr_we_b", 64'(reg_write), 64'h0);

    // Simultaneous push/pop across several pointer wraps.
    tick();
    pipe_wb_valid = 1'b1; pipe_wb_dest = 5'd3; pipe_wb_data = 64'h33;
    wrap_data[0] = {$urandom, $urandom};
    lu_valid = 1'b1; lu_dest = 5'd21; lu_data = wrap_data[0];
    tick();
    pipe_wb_valid = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      wrap_data[k] = {$urandom, $urandom};
      lu_valid = 1'b1; lu_dest = 5'(22 + (k % 8)); lu_data = wrap_data[k];
      query_addr_1 = 5'(22 + (k % 8)); query_addr_2 = 5'(22 + ((k + 7) % 8));
      tick();
    end
    lu_valid = 1'b0;
    @(negedge clk);
    check("wrap_dest", 64'(reg_write_dest), 64'(22 + (11 % 8)));
    check("wrap_data", reg_write_data, wrap_data[11]);
    repeat (3) tick();

    // Randomised traffic; the model compare covers every cycle.
    for (int c = 0; c < 400; c++) begin
      pipe_wb_valid = !model_stall() && ($urandom_range(2) == 0);
      pipe_wb_dest  = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(16, 24));
      pipe_wb_data  = {$urandom, $urandom};
      lu_valid      = $urandom_range(1) == 1;
      lu_dest       = ($urandom_range(9) == 0) ? 5'd31 : 5'($urandom_range(18, 26));
      lu_data       = {$urandom, $urandom};
      query_addr_1  = 5'($urandom_range(16, 31));
      query_addr_2  = 5'($urandom_range(16, 31));
      tick();
    end
    idle_inputs();
    repeat (6) tick();

    // Asynchronous reset with three entries queued.
    for (int k = 0; k < 3; k++) begin
      pipe_wb_valid = 1'b1; pipe_wb_dest = 5'd3; pipe_wb_data = 64'(k);
      lu_valid = 1'b1; lu_dest = 5'(24 + k); lu_data = 64'hC0 + 64'(k);
      tick();
    end
    idle_inputs();
    query_addr_1 = 5'd24;
    @(negedge clk);
    check("pre_rst_we", 64'(reg_write), 64'h1);
    check("pre_rst_pend", 64'(pend_1), 64'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_we", 64'(reg_write), 64'h0);
    check("async_rst_pend", 64'(pend_1), 64'h0);
    check("async_rst_ready", 64'(lu_ready), 64'h1);
    check("async_rst_stall", 64'(stall_req), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk);
      check("post_rst_we", 64'(reg_write), 64'h0);
    end

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
